// File: rtl/iter_magnitude_comparator.sv
// Sequential magnitude comparator. It walks both operands one CHUNK at a time, MSB chunk first,
// stops at the first differing chunk, and shows the result letter and cycle count on a multiplexed display.
module iter_magnitude_comparator #(
    parameter int WIDTH       = 16,
    parameter int CHUNK       = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [3:0]       cycles,
    output logic [7:0]       anode,
    output logic             ca,
    output logic             cb,
    output logic             cc,
    output logic             cd,
    output logic             ce,
    output logic             cf,
    output logic             cg
);

    localparam int K      = WIDTH / CHUNK;
    localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [WIDTH-1:0]  SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [3:0]        LAST_IDX  = 4'(K - 1);
    localparam logic [3:0]        K_CYCLES  = 4'(K);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_G     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_L     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [3:0]        idx;
    logic              result_valid;
    logic [CHUNK-1:0]  top_a;
    logic [CHUNK-1:0]  top_b;

    logic [SCAN_W-1:0] scan_count;
    logic              digit_sel;
    logic [6:0]        letter_seg;
    logic [6:0]        hex_seg;
    logic [6:0]        seg;

    // The operands are shifted left after each equal chunk, so the chunk under test is always the top one.
    assign top_a = op_a[WIDTH-1 -: CHUNK];
    assign top_b = op_b[WIDTH-1 -: CHUNK];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            idx          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            gt           <= 1'b0;
            eq           <= 1'b0;
            lt           <= 1'b0;
            cycles       <= '0;
            result_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Flipping the sign bit turns two's complement into offset binary, so unsigned chunk compares give the signed order.
                        op_a         <= signed_mode ? (a ^ SIGN_MASK) : a;
                        op_b         <= signed_mode ? (b ^ SIGN_MASK) : b;
                        idx          <= '0;
                        gt           <= 1'b0;
                        eq           <= 1'b0;
                        lt           <= 1'b0;
                        result_valid <= 1'b0;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (top_a != top_b) begin
                        gt           <= (top_a > top_b);
                        lt           <= (top_a < top_b);
                        cycles       <= idx + 4'd1;
                        done         <= 1'b1;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else if (idx == LAST_IDX) begin
                        eq           <= 1'b1;
                        cycles       <= K_CYCLES;
                        done         <= 1'b1;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else begin
                        idx  <= idx + 4'd1;
                        op_a <= op_a << CHUNK;
                        op_b <= op_b << CHUNK;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The display scan is free-running and ignores the comparator state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_count <= '0;
            digit_sel  <= 1'b0;
        end else if (scan_count == SCAN_LAST) begin
            scan_count <= '0;
            digit_sel  <= ~digit_sel;
        end else begin
            scan_count <= scan_count + SCAN_W'(1);
        end
    end

    always_comb begin
        hex_seg = SEG_BLANK;
        case (cycles)
            4'h0: hex_seg = 7'b0000001;
            4'h1: hex_seg = 7'b1001111;
            4'h2: hex_seg = 7'b0010010;
            4'h3: hex_seg = 7'b0000110;
            4'h4: hex_seg = 7'b1001100;
            4'h5: hex_seg = 7'b0100100;
            4'h6: hex_seg = 7'b0100000;
            4'h7: hex_seg = 7'b0001111;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0000100;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b1100000;
            4'hC: hex_seg = 7'b0110001;
            4'hD: hex_seg = 7'b1000010;
            4'hE: hex_seg = 7'b0110000;
            4'hF: hex_seg = 7'b0111000;
            default: hex_seg = SEG_BLANK;
        endcase
    end

    always_comb begin
        letter_seg = SEG_L;
        if (gt) begin
            letter_seg = SEG_G;
        end else if (eq) begin
            letter_seg = SEG_E;
        end
    end

    always_comb begin
        seg   = SEG_BLANK;
        anode = digit_sel ? 8'b11111101 : 8'b11111110;
        if (result_valid) begin
            seg = digit_sel ? hex_seg : letter_seg;
        end
    end

    assign {ca, cb, cc, cd, ce, cf, cg} = seg;

endmodule

// File: doc/iter_magnitude_comparator.md
Name: iter_magnitude_comparator

Overview:
- Sequential, parametrised magnitude comparator for the seven-segment lab platform.
- Compares two WIDTH-bit operands, unsigned or two's-complement, CHUNK bits per clock, MSB chunk first, and stops early at the first differing chunk.
- Drives the result letter (G/E/L) on digit 0 and the used cycle count (hex) on digit 1 of the 8-digit display, time-multiplexed.

Parameters:
- WIDTH, 16, operand width in bits. WIDTH % CHUNK must be 0.
- CHUNK, 4, bits compared per clock. K = WIDTH/CHUNK, with 1 <= K <= 15.
- REFRESH_DIV, 100000, clocks per display digit before the scan advances (>= 2).

Ports:
- clk, input, 1: system clock; all state on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: request a comparison; sampled in IDLE or DONE only.
- signed_mode, input, 1: 1 = two's-complement compare; latched with start.
- a, input, WIDTH: operand A; latched with start.
- b, input, WIDTH: operand B; latched with start.
- busy, output, 1: high while in RUN.
- done, output, 1: one-clock pulse when the result registers update.
- gt, output, 1: A > B; held until the next accepted start.
- eq, output, 1: A == B; held until the next accepted start.
- lt, output, 1: A < B; held until the next accepted start.
- cycles, output, 4: number of RUN clocks used by the last comparison (1..K).
- anode, output, 8: active-low digit enables.
- ca, cb, cc, cd, ce, cf, cg, output, 1 each: active-low segment cathodes.

Behaviour:
- Reset (asynchronous, immediate, including mid-RUN):
  - FSM goes to IDLE.
  - busy, done, gt, eq, lt = 0; cycles = 0; result_valid = 0.
  - Scan counter = 0, digit select = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with start=1 at an edge: latch a and b into internal registers, chunk index j = 0, clear gt/eq/lt, go to RUN.
  - When signed_mode=1, the MSB of both latched operands is inverted (offset binary), so all later chunk compares are unsigned.
  - start while in RUN is ignored; operand and mode inputs are not resampled.
- RUN: each clock compares chunk j, bits [WIDTH-1-j*CHUNK -: CHUNK], of both latched operands.
  - Chunks differ: at that edge set gt or lt, cycles = j+1, done = 1, result_valid = 1, go to DONE.
  - Chunks equal and j < K-1: j increments, stay in RUN.
  - Chunks equal and j = K-1: set eq, cycles = K, done = 1, result_valid = 1, go to DONE.
- Timing: start accepted at edge T0, result registered at edge T0+1+j. Latency is 1..K clocks after acceptance.
- Outputs:
  - Exactly one of gt/eq/lt is high whenever result_valid = 1.
  - done is high for exactly one clock per comparison.
  - busy = (state == RUN).
- DONE behaves like IDLE for start, so back-to-back comparisons are possible: a start in the DONE clock begins RUN on the next edge.
- Display scan:
  - Counter counts 0..REFRESH_DIV-1; at wrap it returns to 0 and toggles digit select.
  - select=0: anode = 11111110, cathodes show the result letter.
  - select=1: anode = 11111101, cathodes show hex(cycles).
  - Digits 2-7 are always off.
  - While result_valid = 0, both digits show blank = 1111111.
  - Cathodes {ca..cg}: G = 0100001, E = 0110000, L = 1110001, blank = 1111111.
  - Hex digits use standard active-low encoding, e.g. 1 = 1001111, 4 = 1001100.
- The scan runs independently of the FSM; a comparison in progress does not stall or reset the scan.

Test Plan (WIDTH=16, CHUNK=4, REFRESH_DIV=4):
- a=0x1234, b=0x1234, unsigned, start at T0:
  - busy high T0..T0+4; done pulse and eq=1 at T0+4; cycles=4.
  - Digit0 cathodes 0110000, digit1 1001100.
- a=0x8000, b=0x7FFF, unsigned: gt=1 and done at T0+1, cycles=1. Same operands with signed_mode=1: lt=1, cycles=1.
- a=0x12F0, b=0x12E0, unsigned:
  - gt=1 at T0+3, cycles=3.
  - Then a back-to-back start in the DONE clock with a=0x0001, b=0x0002: gt clears at the accept edge, lt=1 after 4 RUN clocks, cycles=4.
- Start a compare of 0x0000 vs 0x0001 and, one clock into RUN, pulse start with a=0xFFFF: input ignored, final lt=1, cycles=4.
  - Then assert reset mid-RUN of a new compare: busy/gt/eq/lt/done/cycles drop to 0 immediately, both digits blank, no done pulse after release.
- Display after reset release with no compare: anode alternates 11111110 / 11111101 every 4 clocks, cathodes stay 1111111. After an L result with cycles=1, digit0 shows 1110001 and digit1 shows 1001111.
